// File: rtl/mem_io_ctrl_if.sv
// Core-side memory bus: registered address, write data, write strobe,
// and the one-cycle-latency read word returned to the core.
interface mem_io_ctrl_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] RdData;

  modport master (
    output ADDR,
    output DOUT,
    output W,
    input  RdData
  );

  modport slave (
    input  ADDR,
    input  DOUT,
    input  W,
    output RdData
  );
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory-mapped target: data RAM, LED register, synced switches
// and a reload down-counter timer, with a registered read word.
module mem_io_ctrl #(
  parameter int AW   = 7,
  parameter int NLED = 10,
  parameter int NSW  = 10
) (
  input  logic            Clock,
  input  logic            Resetn,
  mem_io_ctrl_if.slave    bus,
  input  logic [NSW-1:0]  SW,
  output logic [NLED-1:0] LEDR,
  output logic            TimerIRQ
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [15:0]    mem [2**AW];
  logic [AW-1:0]  idx;
  logic [3:0]     region;
  logic [1:0]     tsel;
  logic           sel_ram;
  logic           sel_led;
  logic           sel_sw;
  logic           sel_tmr;
  logic           wr_ram;
  logic           wr_led;
  logic           wr_reload;
  logic           wr_ctrl;
  logic [15:0]    reload;
  logic [15:0]    count;
  logic [15:0]    count_n;
  logic           expired;
  logic           expired_n;
  logic           expire;
  logic [NSW-1:0] sync1;
  logic [NSW-1:0] sync2;
  logic [15:0]    rd_next;
  logic [15:0]    tmr_rd;
  logic           unused_bits;

  assign region  = bus.ADDR[15:12];
  assign tsel    = bus.ADDR[1:0];
  assign idx     = bus.ADDR[AW-1:0];
  assign sel_ram = (region == 4'h0);
  assign sel_led = (region == 4'h1);
  assign sel_sw  = (region == 4'h2);
  assign sel_tmr = (region == 4'h3);

  assign wr_ram    = bus.W & sel_ram;
  assign wr_led    = bus.W & sel_led;
  assign wr_reload = bus.W & sel_tmr & (tsel == 2'd0);
  assign wr_ctrl   = bus.W & sel_tmr & (tsel == 2'd2);

  // RAM aliases across the ignored middle address bits
  assign unused_bits = ^bus.ADDR[11:AW];

  assign TimerIRQ = expired;

  always_comb begin
    state_n = state;
    if (wr_ctrl)
      state_n = bus.DOUT[0] ? RUN : IDLE;
  end

  // Force-reload beats decrement; expiry beats a clear
  always_comb begin
    count_n   = count;
    expired_n = expired;
    expire    = (state == RUN) && (count == 16'd0);
    if (wr_ctrl && bus.DOUT[2])
      count_n = reload;
    else if (state == RUN)
      count_n = (count == 16'd0) ? reload
                                 : count - 16'd1;
    if (wr_ctrl && bus.DOUT[1])
      expired_n = 1'b0;
    if (expire)
      expired_n = 1'b1;
  end

  always_comb begin
    tmr_rd = 16'h0000;
    case (tsel)
      2'd0:    tmr_rd = reload;
      2'd1:    tmr_rd = count;
      2'd2:    tmr_rd = {13'b0, expired, 1'b0,
                         state == RUN};
      default: tmr_rd = 16'h0000;
    endcase
  end

  always_comb begin
    rd_next = 16'h0000;
    unique case (1'b1)
      sel_ram: rd_next = bus.W ? bus.DOUT : mem[idx];
      sel_led: rd_next = {{(16-NLED){1'b0}}, LEDR};
      sel_sw:  rd_next = {{(16-NSW){1'b0}}, sync2};
      sel_tmr: rd_next = tmr_rd;
      default: rd_next = 16'h0000;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn && wr_ram)
      mem[idx] <= bus.DOUT;
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      bus.RdData <= 16'h0000;
      LEDR       <= '0;
      reload     <= 16'hFFFF;
      count      <= 16'hFFFF;
      expired    <= 1'b0;
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
    end else begin
      bus.RdData <= rd_next;
      if (wr_led)
        LEDR <= bus.DOUT[NLED-1:0];
      if (wr_reload)
        reload <= bus.DOUT;
      count   <= count_n;
      expired <= expired_n;
      state   <= state_n;
      sync1   <= SW;
      sync2   <= sync1;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed-vector bench for mem_io_ctrl: table of bus cycles plus
// hand sequences for switch sync, timer corners and async reset.
module tb_mem_io_ctrl;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] rd;
    logic [9:0]  led;
    logic        irq;
  } vec_t;

  localparam int NV = 27;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic       TimerIRQ;

  int nvec = 0;
  int nbad = 0;

  vec_t tbl [NV];

  mem_io_ctrl_if bus ();

  mem_io_ctrl #(
    .AW(7), .NLED(10), .NSW(10)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .bus      (bus),
    .SW       (SW),
    .LEDR     (LEDR),
    .TimerIRQ (TimerIRQ)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] a,
                     input logic [15:0] d,
                     input logic w);
    bus.ADDR = a;
    bus.DOUT = d;
    bus.W    = w;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    tbl[0]  = '{16'h1000, 16'h0000, 1'b0, 16'h0000, 10'h000, 1'b0};
    tbl[1]  = '{16'h3001, 16'h0000, 1'b0, 16'hFFFF, 10'h000, 1'b0};
    tbl[2]  = '{16'h3002, 16'h0000, 1'b0, 16'h0000, 10'h000, 1'b0};
    tbl[3]  = '{16'h3000, 16'h0000, 1'b0, 16'hFFFF, 10'h000, 1'b0};
    tbl[4]  = '{16'h0005, 16'hBEEF, 1'b1, 16'hBEEF, 10'h000, 1'b0};
    tbl[5]  = '{16'h0006, 16'h1234, 1'b1, 16'h1234, 10'h000, 1'b0};
    tbl[6]  = '{16'h0005, 16'h0000, 1'b0, 16'hBEEF, 10'h000, 1'b0};
    tbl[7]  = '{16'h0085, 16'h0000, 1'b0, 16'hBEEF, 10'h000, 1'b0};
    tbl[8]  = '{16'h0006, 16'h5555, 1'b1, 16'h5555, 10'h000, 1'b0};
    tbl[9]  = '{16'h0006, 16'h0000, 1'b0, 16'h5555, 10'h000, 1'b0};
    tbl[10] = '{16'h1000, 16'h03A5, 1'b1, 16'h0000, 10'h3A5, 1'b0};
    tbl[11] = '{16'h1000, 16'h0000, 1'b0, 16'h03A5, 10'h3A5, 1'b0};
    tbl[12] = '{16'h4000, 16'hFFFF, 1'b1, 16'h0000, 10'h3A5, 1'b0};
    tbl[13] = '{16'hF000, 16'h0000, 1'b0, 16'h0000, 10'h3A5, 1'b0};
    tbl[14] = '{16'h1000, 16'h0000, 1'b0, 16'h03A5, 10'h3A5, 1'b0};
    tbl[15] = '{16'h2000, 16'h1234, 1'b1, 16'h0000, 10'h3A5, 1'b0};
    tbl[16] = '{16'h3000, 16'h0003, 1'b1, 16'hFFFF, 10'h3A5, 1'b0};
    tbl[17] = '{16'h3002, 16'h0005, 1'b1, 16'h0000, 10'h3A5, 1'b0};
    tbl[18] = '{16'h3001, 16'h0000, 1'b0, 16'h0003, 10'h3A5, 1'b0};
    tbl[19] = '{16'h3001, 16'h0000, 1'b0, 16'h0002, 10'h3A5, 1'b0};
    tbl[20] = '{16'h3001, 16'h0000, 1'b0, 16'h0001, 10'h3A5, 1'b0};
    tbl[21] = '{16'h3001, 16'h0000, 1'b0, 16'h0000, 10'h3A5, 1'b1};
    tbl[22] = '{16'h3001, 16'h0000, 1'b0, 16'h0003, 10'h3A5, 1'b1};
    tbl[23] = '{16'h3002, 16'h0000, 1'b0, 16'h0005, 10'h3A5, 1'b1};
    tbl[24] = '{16'h3002, 16'h0003, 1'b1, 16'h0005, 10'h3A5, 1'b0};
    tbl[25] = '{16'h3002, 16'h0000, 1'b0, 16'h0001, 10'h3A5, 1'b1};
    tbl[26] = '{16'h3001, 16'h0000, 1'b0, 16'h0003, 10'h3A5, 1'b1};

    Resetn   = 1'b1;
    SW       = '0;
    bus.ADDR = 16'h0000;
    bus.DOUT = 16'h0000;
    bus.W    = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_rd", bus.RdData, 16'h0000);
    check("rst_led", {6'b0, LEDR}, 16'h0000);
    check("rst_irq", {15'b0, TimerIRQ}, 16'h0000);
    Resetn = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].addr, tbl[i].dout, tbl[i].w);
      check($sformatf("v%0d_rd", i),
            bus.RdData, tbl[i].rd);
      check($sformatf("v%0d_led", i),
            {6'b0, LEDR}, {6'b0, tbl[i].led});
      check($sformatf("v%0d_irq", i),
            {15'b0, TimerIRQ}, {15'b0, tbl[i].irq});
    end

    // switch synchronizer: visible on the 3rd edge
    bus.ADDR = 16'h2000;
    bus.W    = 1'b0;
    #2 SW = 10'h2C1;
    cyc(16'h2000, 16'h0000, 1'b0);
    check("sw_e1", bus.RdData, 16'h0000);
    cyc(16'h2000, 16'h0000, 1'b0);
    check("sw_e2", bus.RdData, 16'h0000);
    cyc(16'h2000, 16'h0000, 1'b0);
    check("sw_e3", bus.RdData, 16'h02C1);
    cyc(16'h2000, 16'h0000, 1'b0);
    check("sw_e4", bus.RdData, 16'h02C1);

    // RELOAD=0: expiry every cycle beats the clear
    cyc(16'h3000, 16'h0000, 1'b1);
    cyc(16'h3002, 16'h0005, 1'b1);
    cyc(16'h3002, 16'h0003, 1'b1);
    check("r0_irq1", {15'b0, TimerIRQ}, 16'h0001);
    cyc(16'h3002, 16'h0003, 1'b1);
    check("r0_rd2", bus.RdData, 16'h0005);
    check("r0_irq2", {15'b0, TimerIRQ}, 16'h0001);
    cyc(16'h3002, 16'h0003, 1'b1);
    check("r0_rd3", bus.RdData, 16'h0005);
    check("r0_irq3", {15'b0, TimerIRQ}, 16'h0001);
    cyc(16'h3001, 16'h0000, 1'b0);
    check("r0_cnt", bus.RdData, 16'h0000);

    // disabled timer holds COUNT
    cyc(16'h3002, 16'h0000, 1'b1);
    check("dis_rd", bus.RdData, 16'h0005);
    cyc(16'h3000, 16'h0005, 1'b1);
    cyc(16'h3002, 16'h0004, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(16'h3001, 16'h0000, 1'b0);
      check($sformatf("frz%0d", i),
            bus.RdData, 16'h0005);
    end
    cyc(16'h3002, 16'h0000, 1'b0);
    check("frz_stat", bus.RdData, 16'h0004);
    check("frz_irq", {15'b0, TimerIRQ}, 16'h0001);

    // async reset while running at COUNT=2
    cyc(16'h3002, 16'h0001, 1'b1);
    cyc(16'h3001, 16'h0000, 1'b0);
    check("run5", bus.RdData, 16'h0005);
    cyc(16'h3001, 16'h0000, 1'b0);
    check("run4", bus.RdData, 16'h0004);
    cyc(16'h3001, 16'h0000, 1'b0);
    check("run3", bus.RdData, 16'h0003);
    bus.W = 1'b1;
    #2 Resetn = 1'b1;
    #1;
    check("ar_rd", bus.RdData, 16'h0000);
    check("ar_irq", {15'b0, TimerIRQ}, 16'h0000);
    check("ar_led", {6'b0, LEDR}, 16'h0000);
    #1 Resetn = 1'b0;
    cyc(16'h3001, 16'h0000, 1'b0);
    check("ar_cnt", bus.RdData, 16'hFFFF);
    cyc(16'h3002, 16'h0000, 1'b0);
    check("ar_stat", bus.RdData, 16'h0000);
    cyc(16'h3001, 16'h0000, 1'b0);
    check("ar_cnt2", bus.RdData, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
Name: mem_io_ctrl

Overview:
- Memory-mapped bus target sitting directly downstream of the processor core. Consumes the core's registered `ADDR`, `DOUT` and `W` outputs.
- Decodes the address into four regions: data RAM, LED output register, synchronized switch input, and a reload down-counter timer.
- Returns a single registered read word, `RdData`, which the top level routes to the core's memory-data input.

Parameters:
- AW, 7, RAM word-address width (RAM depth = 2**AW words of 16 bits).
- NLED, 10, width of the LED output register.
- NSW, 10, width of the switch input.

Ports:
- Clock  in  1  system clock, all state updates on the rising edge.
- Resetn  in  1  asynchronous, active-high reset. Asserting 1 clears all registers immediately.
- ADDR  in  16  word address from the core.
- DOUT  in  16  write data from the core.
- W  in  1  write strobe. A write occurs on the rising edge where W=1.
- SW  in  NSW  asynchronous board switches.
- RdData  out  16  registered read data for the address presented in the previous cycle.
- LEDR  out  NLED  LED register contents.
- TimerIRQ  out  1  sticky timer-expired flag.

Behaviour:
- Address decode uses ADDR[15:12]. A region is selected combinationally every cycle.
  - 0x0: RAM. Index is ADDR[AW-1:0]; ADDR[11:AW] is ignored, so the RAM aliases.
  - 0x1: LED register.
  - 0x2: switch input (read-only).
  - 0x3: timer. ADDR[1:0] selects 0 = RELOAD, 1 = COUNT (read-only), 2 = CTRL/STATUS.
  - Other regions: reads return 0x0000 and writes are ignored.
- Reset values: RdData=0, LEDR=0, RELOAD=0xFFFF, COUNT=0xFFFF, enable=0, expired=0, switch synchronizer flops=0. RAM contents are not reset and are undefined at power-up.
- Read latency: exactly 1 cycle. On every rising edge, RdData <= data selected by ADDR in that cycle. No read strobe; reads have no side effects.
- Read/write to the same RAM address in the same cycle is write-first: RdData gets DOUT.
- Writes: on a rising edge with W=1, the selected target takes DOUT.
  - RAM: word at index is written.
  - LED: LEDR <= DOUT[NLED-1:0].
  - Switch region: write ignored.
  - RELOAD: RELOAD <= DOUT.
  - CTRL: bit0 = enable. Writing bit1=1 clears expired. Writing bit2=1 forces COUNT <= RELOAD.
  - COUNT: write ignored.
- Switch input: 2-flop synchronizer per bit. A read returns {zero-extend, synced SW}, so a switch change appears in RdData no earlier than 3 edges later.
- Timer state machine, 2 states:
  - IDLE (enable=0): COUNT holds.
  - RUN (enable=1): each edge, if COUNT!=0 then COUNT <= COUNT-1; if COUNT==0 then COUNT <= RELOAD and expired <= 1.
  - Transitions follow the enable bit written via CTRL.
- Timer simultaneous events on the same edge:
  - Expiry and a CTRL write clearing expired: set wins.
  - Force-reload and decrement: reload wins.
  - RELOAD write while COUNT==0: the new RELOAD value is not used this edge; the old one is loaded.
- STATUS read format: {13'b0, expired, 1'b0, enable}.
- TimerIRQ = expired, driven directly from the flop.
- RELOAD=0 with enable=1: expired sets every cycle and COUNT stays 0.
- Reset mid-operation: Resetn asserted clears state asynchronously regardless of W. The first edge after deassertion behaves as a normal cycle.

Test Plan:
- Reset then read: Resetn pulse, ADDR=0x1000 → LEDR=0, TimerIRQ=0. ADDR=0x3001 → RdData=0xFFFF next cycle.
- RAM round trip: write 0xBEEF to 0x0005, write 0x1234 to 0x0006, read 0x0005 → RdData=0xBEEF after 1 cycle. Read 0x0085 (alias, AW=7) → 0xBEEF. Same-cycle write 0x5555 + read at 0x0006 → RdData=0x5555.
- LED/switch: write 0x03A5 to 0x1000 → LEDR=0x3A5 after the edge. Set SW=0x2C1 asynchronously; read 0x2000 continuously → RdData=0x02C1 no earlier than the 3rd edge and stable thereafter. Write to 0x2000 has no effect.
- Timer expiry: RELOAD=3, CTRL=0x5 (enable + force reload) → COUNT sequence 3,2,1,0,3. TimerIRQ rises on the edge COUNT goes 0→3. Write CTRL=0x3 → TimerIRQ=0, enable stays 1.
- Timer corner cases: RELOAD=0 with enable → TimerIRQ stays 1 even when clear is written each cycle. CTRL=0x0 → COUNT frozen.
- Unmapped and reset mid-op: write 0x4000 → no state change, read 0xF000 → RdData=0. Assert Resetn while timer is running at COUNT=2 → COUNT=0xFFFF, enable=0 immediately, without waiting for a clock edge.
